// File: rtl/axis_traffic_gen.sv
// AXI-Stream packet source: emits num_pkts packets of pkt_len beats with a seq/beat/src payload, rotating tdest over a mask.
// First beat one cycle after an accepted start; beats advance only on tvalid&&tready and hold stable while stalled.
module axis_traffic_gen #(
  parameter int TDATA_WIDTH = 512,
  parameter int TDEST_WIDTH = 4,
  parameter int NUM_DEST    = 4,
  parameter int SRC_ID      = 0,
  parameter int LEN_WIDTH   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [15:0]            num_pkts,
  input  logic [LEN_WIDTH-1:0]   pkt_len,
  input  logic [NUM_DEST-1:0]    dest_mask,
  output logic                   busy,
  output logic                   done,
  output logic [15:0]            pkt_count,
  output logic                   axis_out_tvalid,
  input  logic                   axis_out_tready,
  output logic [TDATA_WIDTH-1:0] axis_out_tdata,
  output logic                   axis_out_tlast,
  output logic [TDEST_WIDTH-1:0] axis_out_tdest
);

  typedef enum logic [1:0] {IDLE, SEND, FIN} state_t;

  state_t                 state_q, state_d;
  logic [15:0]            num_pkts_q, num_pkts_d;
  logic [LEN_WIDTH-1:0]   len_q, len_d;
  logic [NUM_DEST-1:0]    mask_q, mask_d;
  logic [15:0]            pkt_count_q, pkt_count_d;
  logic [LEN_WIDTH-1:0]   beat_q, beat_d;
  logic [15:0]            seq_q, seq_d;
  logic [TDEST_WIDTH-1:0] dest_q, dest_d;
  logic                   last_beat;

  function automatic logic [TDEST_WIDTH-1:0] lowest_bit(input logic [NUM_DEST-1:0] m);
    lowest_bit = '0;
    for (int i = NUM_DEST - 1; i >= 0; i--)
      if (m[i]) lowest_bit = TDEST_WIDTH'(i);
  endfunction

  // Next set bit strictly above cur, wrapping to the lowest set bit.
  function automatic logic [TDEST_WIDTH-1:0] next_bit(input logic [NUM_DEST-1:0] m,
                                                      input logic [TDEST_WIDTH-1:0] cur);
    logic found;
    found    = 1'b0;
    next_bit = lowest_bit(m);
    for (int i = 0; i < NUM_DEST; i++) begin
      if (!found && m[i] && (TDEST_WIDTH'(i) > cur)) begin
        next_bit = TDEST_WIDTH'(i);
        found    = 1'b1;
      end
    end
  endfunction

  assign last_beat = (beat_q == len_q - LEN_WIDTH'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      num_pkts_q  <= '0;
      len_q       <= '0;
      mask_q      <= '0;
      pkt_count_q <= '0;
      beat_q      <= '0;
      seq_q       <= '0;
      dest_q      <= '0;
    end else begin
      state_q     <= state_d;
      num_pkts_q  <= num_pkts_d;
      len_q       <= len_d;
      mask_q      <= mask_d;
      pkt_count_q <= pkt_count_d;
      beat_q      <= beat_d;
      seq_q       <= seq_d;
      dest_q      <= dest_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    num_pkts_d  = num_pkts_q;
    len_d       = len_q;
    mask_d      = mask_q;
    pkt_count_d = pkt_count_q;
    beat_d      = beat_q;
    seq_d       = seq_q;
    dest_d      = dest_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          num_pkts_d  = num_pkts;
          len_d       = (pkt_len == '0) ? LEN_WIDTH'(1) : pkt_len;
          mask_d      = dest_mask;
          pkt_count_d = '0;
          beat_d      = '0;
          seq_d       = '0;
          dest_d      = lowest_bit(dest_mask);
          state_d     = (num_pkts == 16'd0 || dest_mask == '0) ? FIN : SEND;
        end
      end
      SEND: begin
        if (axis_out_tready) begin
          if (last_beat) begin
            pkt_count_d = pkt_count_q + 16'd1;
            seq_d       = seq_q + 16'd1;
            beat_d      = '0;
            dest_d      = next_bit(mask_q, dest_q);
            if (pkt_count_q + 16'd1 == num_pkts_q) state_d = FIN;
          end else begin
            beat_d = beat_q + LEN_WIDTH'(1);
          end
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    axis_out_tvalid = (state_q == SEND);
    axis_out_tlast  = (state_q == SEND) && last_beat;
    axis_out_tdest  = dest_q;
    axis_out_tdata  = '0;
    if (state_q == SEND) begin
      axis_out_tdata[15:0]                 = 16'(beat_q);
      axis_out_tdata[31:16]                = seq_q;
      axis_out_tdata[32 +: TDEST_WIDTH]    = TDEST_WIDTH'(SRC_ID);
    end
    busy      = (state_q == SEND);
    done      = (state_q == FIN);
    pkt_count = pkt_count_q;
  end

endmodule

// File: tb/tb_axis_traffic_gen.sv
// Directed bench for axis_traffic_gen: runs, stalls, zero-length/zero-count, reset mid-packet, start while busy.
module tb_axis_traffic_gen;
  localparam int TDATA_WIDTH = 512;
  localparam int TDEST_WIDTH = 4;
  localparam int NUM_DEST    = 4;
  localparam int SRC_ID      = 2;
  localparam int LEN_WIDTH   = 8;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   start;
  logic [15:0]            num_pkts;
  logic [LEN_WIDTH-1:0]   pkt_len;
  logic [NUM_DEST-1:0]    dest_mask;
  logic                   busy, done;
  logic [15:0]            pkt_count;
  logic                   tvalid, tready, tlast;
  logic [TDATA_WIDTH-1:0] tdata;
  logic [TDEST_WIDTH-1:0] tdest;

  int vectors = 0;
  int miscompares = 0;

  logic [47:0]            got_dat[$];
  logic                   got_last[$];
  logic [TDEST_WIDTH-1:0] got_dest[$];
  int                     got_cyc[$];
  int done_cnt, done_cyc, stall_err, overlap_err, hi_err;

  always #5 clk = ~clk;

  axis_traffic_gen #(
    .TDATA_WIDTH(TDATA_WIDTH), .TDEST_WIDTH(TDEST_WIDTH), .NUM_DEST(NUM_DEST),
    .SRC_ID(SRC_ID), .LEN_WIDTH(LEN_WIDTH)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .num_pkts(num_pkts), .pkt_len(pkt_len),
    .dest_mask(dest_mask), .busy(busy), .done(done), .pkt_count(pkt_count),
    .axis_out_tvalid(tvalid), .axis_out_tready(tready), .axis_out_tdata(tdata),
    .axis_out_tlast(tlast), .axis_out_tdest(tdest)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [47:0] exp_dat(input int seq, input int beat);
    return (48'(SRC_ID) << 32) | (48'(seq) << 16) | 48'(beat);
  endfunction

  task automatic do_start(input int n, input int l, input logic [NUM_DEST-1:0] m);
    num_pkts  = 16'(n);
    pkt_len   = LEN_WIDTH'(l);
    dest_mask = m;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  // Called at the negedge after start was accepted; records every handshaked beat.
  task automatic collect(input bit stall, input int budget);
    bit                     held;
    logic [TDATA_WIDTH-1:0] hd;
    logic                   hl;
    logic [TDEST_WIDTH-1:0] hdst;
    held = 1'b0; hd = '0; hl = 1'b0; hdst = '0;
    got_dat.delete(); got_last.delete(); got_dest.delete(); got_cyc.delete();
    done_cnt = 0; done_cyc = -1; stall_err = 0; overlap_err = 0; hi_err = 0;
    for (int cyc = 0; cyc < budget; cyc++) begin
      tready = stall ? (cyc % 3 == 0) : 1'b1;
      if (held && (tvalid !== 1'b1 || tdata !== hd || tlast !== hl || tdest !== hdst)) stall_err++;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (busy === 1'b1 && done === 1'b1) overlap_err++;
      held = 1'b0;
      if (tvalid === 1'b1) begin
        if (|tdata[TDATA_WIDTH-1:32+TDEST_WIDTH]) hi_err++;
        if (tready) begin
          got_dat.push_back(tdata[47:0]);
          got_last.push_back(tlast);
          got_dest.push_back(tdest);
          got_cyc.push_back(cyc);
        end else begin
          held = 1'b1; hd = tdata; hl = tlast; hdst = tdest;
        end
      end
      @(negedge clk);
      if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
    end
    tready = 1'b1;
  endtask

  task automatic check_beats(input string tag, input int np, input int len, input logic [15:0] dests);
    chk({tag, "_nbeats"}, 64'(got_dat.size()), 64'(np * len));
    for (int p = 0; p < np; p++) begin
      for (int b = 0; b < len; b++) begin
        int i;
        i = p * len + b;
        if (i < got_dat.size()) begin
          chk({tag, "_dat"},  64'(got_dat[i]), 64'(exp_dat(p, b)));
          chk({tag, "_last"}, 64'(got_last[i]), 64'(b == len - 1));
          chk({tag, "_dest"}, 64'(got_dest[i]), 64'(dests[4*p +: 4]));
        end
      end
    end
    chk({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
    chk({tag, "_overlap"},  64'(overlap_err), 64'd0);
    chk({tag, "_hi_zero"},  64'(hi_err), 64'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; num_pkts = '0; pkt_len = '0; dest_mask = '0; tready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_tvalid", 64'(tvalid), 64'd0);
    chk("rst_tlast",  64'(tlast), 64'd0);
    chk("rst_tdata",  64'(|tdata), 64'd0);
    chk("rst_tdest",  64'(tdest), 64'd0);
    chk("rst_busy",   64'(busy), 64'd0);
    chk("rst_done",   64'(done), 64'd0);
    chk("rst_pktcnt", 64'(pkt_count), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // 3 packets x 2 beats, continuous ready
    do_start(3, 2, 4'b1110);
    chk("t1_busy", 64'(busy), 64'd1);
    collect(1'b0, 100);
    check_beats("t1", 3, 2, 16'h0321);
    if (got_cyc.size() == 6) begin
      chk("t1_first_cyc", 64'(got_cyc[0]), 64'd0);
      chk("t1_no_bubble", 64'(got_cyc[5] - got_cyc[0]), 64'd5);
      chk("t1_done_cyc",  64'(done_cyc), 64'(got_cyc[5] + 1));
    end
    chk("t1_pktcnt", 64'(pkt_count), 64'd3);

    // same run with ready pattern 1,0,0,...
    do_start(3, 2, 4'b1110);
    collect(1'b1, 200);
    check_beats("t2", 3, 2, 16'h0321);
    chk("t2_stable", 64'(stall_err), 64'd0);
    chk("t2_pktcnt", 64'(pkt_count), 64'd3);

    // length 0 treated as 1, single-bit mask
    do_start(2, 0, 4'b0001);
    collect(1'b0, 100);
    check_beats("t3", 2, 1, 16'h0000);
    chk("t3_pktcnt", 64'(pkt_count), 64'd2);

    // zero packets, then zero mask
    do_start(0, 2, 4'b1110);
    collect(1'b0, 20);
    chk("t4a_nbeats", 64'(got_dat.size()), 64'd0);
    chk("t4a_done_cnt", 64'(done_cnt), 64'd1);
    chk("t4a_done_cyc", 64'(done_cyc), 64'd0);
    chk("t4a_pktcnt", 64'(pkt_count), 64'd0);
    do_start(3, 2, 4'b0000);
    collect(1'b0, 20);
    chk("t4b_nbeats", 64'(got_dat.size()), 64'd0);
    chk("t4b_done_cnt", 64'(done_cnt), 64'd1);
    chk("t4b_pktcnt", 64'(pkt_count), 64'd0);

    // reset during beat 1 of a 4-beat packet
    tready = 1'b1;
    do_start(2, 4, 4'b0110);
    chk("t5_beat0", 64'(tdata[47:0]), 64'(exp_dat(0, 0)));
    @(negedge clk);
    chk("t5_beat1", 64'(tdata[47:0]), 64'(exp_dat(0, 1)));
    rst = 1'b1;
    @(negedge clk);
    chk("t5_tvalid", 64'(tvalid), 64'd0);
    chk("t5_busy",   64'(busy), 64'd0);
    chk("t5_pktcnt", 64'(pkt_count), 64'd0);
    chk("t5_tdest",  64'(tdest), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    do_start(1, 2, 4'b0100);
    collect(1'b0, 50);
    check_beats("t5r", 1, 2, 16'h0002);

    // start while busy must be ignored
    do_start(2, 1, 4'b1000);
    chk("t6_beat0_dat",  64'(tdata[47:0]), 64'(exp_dat(0, 0)));
    chk("t6_beat0_dest", 64'(tdest), 64'd3);
    num_pkts = 16'd5; pkt_len = 8'd3; dest_mask = 4'b0001; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    collect(1'b0, 50);
    chk("t6_nbeats", 64'(got_dat.size()), 64'd1);
    if (got_dat.size() == 1) begin
      chk("t6_dat",  64'(got_dat[0]), 64'(exp_dat(1, 0)));
      chk("t6_dest", 64'(got_dest[0]), 64'd3);
      chk("t6_last", 64'(got_last[0]), 64'd1);
    end
    chk("t6_done_cnt", 64'(done_cnt), 64'd1);
    chk("t6_pktcnt",   64'(pkt_count), 64'd2);
    chk("t6_idle_tvalid", 64'(tvalid), 64'd0);
    chk("t6_idle_busy",   64'(busy), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
